// File: rtl/icache_if2_select.sv
// IF2 word select: picks the hit way's 32-bit word (or the AXI refill word on a miss) with no added latency.
// A downstream stall captures the selected word in a hold register, so the SRAM and AXI sources may change while ID is stalled.
module icache_if2_select #(
    parameter int WAYS   = 8,
    parameter int LINE_W = 64,
    parameter int AXI_W  = 64,
    parameter int PC_W   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PC_W-1:0]          pc_i,
    input  logic [WAYS-1:0]          hit_i,
    input  logic                     valid_i,
    input  logic [3:0]               trap_i,
    input  logic                     kill_i,
    input  logic                     flush_i,
    input  logic                     id_ready_i,
    input  logic [WAYS*LINE_W-1:0]   sram_rdata_i,
    input  logic [AXI_W-1:0]         axi_rdata_i,
    output logic                     valid_o,
    output logic [3:0]               trap_o,
    output logic                     ready_o,
    output logic [31:0]              inst_o,
    output logic                     hit_err_o
);

    localparam int LINE_WORDS = LINE_W / 32;
    localparam int AXI_WORDS  = AXI_W / 32;

    typedef enum logic {
        LIVE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     hold_q;
    logic [31:0]     live_word;
    logic [31:0]     axi_word;
    logic [31:0]     way_word [WAYS];
    logic [PC_W-1:0] line_idx;
    logic [PC_W-1:0] axi_idx;
    logic            go;
    logic            capture;

    // Masking the shifted PC gives index 0 for single-word widths without a zero-width slice.
    assign line_idx = (pc_i >> 2) & PC_W'(LINE_WORDS - 1);
    assign axi_idx  = (pc_i >> 2) & PC_W'(AXI_WORDS - 1);

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            way_word[w] = sram_rdata_i[w*LINE_W +: 32];
            for (int k = 1; k < LINE_WORDS; k++) begin
                if (line_idx == PC_W'(k)) begin
                    way_word[w] = sram_rdata_i[w*LINE_W + k*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        axi_word = axi_rdata_i[31:0];
        for (int k = 1; k < AXI_WORDS; k++) begin
            if (axi_idx == PC_W'(k)) begin
                axi_word = axi_rdata_i[k*32 +: 32];
            end
        end
    end

    // Walk from the top way down so the lowest-index hit has the last word.
    always_comb begin
        live_word = axi_word;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_i[w]) begin
                live_word = way_word[w];
            end
        end
    end

    assign go        = valid_i & ~kill_i & ~flush_i;
    assign valid_o   = go;
    assign trap_o    = trap_i;
    assign ready_o   = (go && trap_i == 4'd0) ? id_ready_i : 1'b1;
    assign hit_err_o = valid_i & ($countones(hit_i) > 1);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        inst_o  = live_word;
        unique case (state_q)
            LIVE: begin
                if (go && !id_ready_i) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                inst_o = hold_q;
                if (id_ready_i || flush_i) begin
                    state_d = LIVE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LIVE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_q <= live_word;
            end
        end
    end

endmodule

// File: tb/tb_icache_if2_select.sv
// Bench for icache_if2_select: default 8x64/64 instance and a 4x128/32 instance driven with shared controls.
module tb_icache_if2_select;

    logic         clk = 1'b0;
    logic         rst, valid, kill, flush, id_ready;
    logic [3:0]   trap;
    logic [63:0]  pc;

    logic [7:0]   hit_a;
    logic [511:0] sram_a;
    logic [63:0]  axi_a;
    logic         valid_a, ready_a, err_a;
    logic [3:0]   trap_a;
    logic [31:0]  inst_a;

    logic [3:0]   hit_b;
    logic [511:0] sram_b;
    logic [31:0]  axi_b;
    logic         valid_b, ready_b, err_b;
    logic [3:0]   trap_b;
    logic [31:0]  inst_b;

    int           tests = 0;
    int           fails = 0;
    bit           held [2];
    logic [31:0]  hw   [2];

    always #5 clk = ~clk;

    icache_if2_select dut_a (
        .clk(clk), .rst(rst), .pc_i(pc), .hit_i(hit_a), .valid_i(valid),
        .trap_i(trap), .kill_i(kill), .flush_i(flush), .id_ready_i(id_ready),
        .sram_rdata_i(sram_a), .axi_rdata_i(axi_a), .valid_o(valid_a),
        .trap_o(trap_a), .ready_o(ready_a), .inst_o(inst_a), .hit_err_o(err_a)
    );

    icache_if2_select #(.WAYS(4), .LINE_W(128), .AXI_W(32), .PC_W(64)) dut_b (
        .clk(clk), .rst(rst), .pc_i(pc), .hit_i(hit_b), .valid_i(valid),
        .trap_i(trap), .kill_i(kill), .flush_i(flush), .id_ready_i(id_ready),
        .sram_rdata_i(sram_b), .axi_rdata_i(axi_b), .valid_o(valid_b),
        .trap_o(trap_b), .ready_o(ready_b), .inst_o(inst_b), .hit_err_o(err_b)
    );

    // Reference word: word number = (pc / 4) mod words-per-line, first set hit wins, else AXI.
    function automatic logic [31:0] ref_live(logic [63:0] p, logic [7:0] hit, int nways,
                                             logic [511:0] sram, int linew,
                                             logic [63:0] axi, int axiw);
        int          li = int'((p >> 2) % 64'(linew / 32));
        int          ai = int'((p >> 2) % 64'(axiw / 32));
        bit          found = 1'b0;
        logic [31:0] r = axi[ai*32 +: 32];
        for (int w = 0; w < nways; w++) begin
            if (hit[w] && !found) begin
                found = 1'b1;
                r = sram[w*linew + li*32 +: 32];
            end
        end
        return r;
    endfunction

    function automatic int popc(logic [7:0] h);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(h[i]);
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] live_of(int i);
        if (i == 0) return ref_live(pc, hit_a, 8, sram_a, 64, axi_a, 64);
        return ref_live(pc, {4'b0, hit_b}, 4, sram_b, 128, {32'b0, axi_b}, 32);
    endfunction

    task automatic check_all(string t);
        bit go    = valid && !kill && !flush;
        bit exp_r = (go && trap == 4'd0) ? id_ready : 1'b1;
        chk({t, "_valid_a"}, 32'(valid_a), 32'(go));
        chk({t, "_valid_b"}, 32'(valid_b), 32'(go));
        chk({t, "_ready_a"}, 32'(ready_a), 32'(exp_r));
        chk({t, "_ready_b"}, 32'(ready_b), 32'(exp_r));
        chk({t, "_trap_a"},  32'(trap_a),  32'(trap));
        chk({t, "_trap_b"},  32'(trap_b),  32'(trap));
        chk({t, "_err_a"},   32'(err_a),   32'(valid && popc(hit_a) > 1));
        chk({t, "_err_b"},   32'(err_b),   32'(valid && popc({4'b0, hit_b}) > 1));
        chk({t, "_inst_a"},  inst_a, held[0] ? hw[0] : live_of(0));
        chk({t, "_inst_b"},  inst_b, held[1] ? hw[1] : live_of(1));
    endtask

    // Check outputs mid-cycle, advance the model across the rising edge, return at the next falling edge.
    task automatic step(string t);
        bit go = valid && !kill && !flush;
        #1;
        check_all(t);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                held[i] = 1'b0;
                hw[i]   = 32'd0;
            end else if (!held[i]) begin
                if (go && !id_ready) begin
                    held[i] = 1'b1;
                    hw[i]   = live_of(i);
                end
            end else if (id_ready || flush) begin
                held[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_sources();
        for (int k = 0; k < 16; k++) begin
            sram_a[k*32 +: 32] = $urandom;
            sram_b[k*32 +: 32] = $urandom;
        end
        axi_a = {$urandom, $urandom};
        axi_b = $urandom;
        hit_a = 8'($urandom);
        hit_b = 4'($urandom);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; kill = 1'b0; flush = 1'b0; id_ready = 1'b1;
        trap = 4'd0; pc = 64'd0;
        hit_a = '0; sram_a = '0; axi_a = '0;
        hit_b = '0; sram_b = '0; axi_b = '0;
        held[0] = 1'b0; held[1] = 1'b0; hw[0] = '0; hw[1] = '0;
        repeat (2) @(negedge clk);
        step("reset");
        rst = 1'b0;
        #1;
        chk("rst_hold_a", dut_a.hold_q, 32'd0);
        chk("idle_ready", 32'(ready_a), 32'd1);
        step("idle");

        // Hit select; B uses pc[3:2] = 1
        valid = 1'b1; pc = 64'h0000_0000_1000_0004;
        sram_a[3*64 +: 64]   = {32'hBBBB0003, 32'hAAAA0003};
        sram_b[3*128 +: 128] = {32'h000000D3, 32'h000000C3, 32'h000000B3, 32'h000000A3};
        hit_a = 8'h08; hit_b = 4'h8;
        #1;
        chk("hit_sel_a", inst_a, 32'hBBBB0003);
        chk("hit_sel_b", inst_b, 32'h000000B3);
        step("hit");

        // Miss via AXI; B has a single AXI word regardless of pc
        hit_a = '0; hit_b = '0;
        axi_a = 64'h00100093_00000013; axi_b = 32'h0BADF00D; pc = 64'd0;
        #1;
        chk("miss_lo_a", inst_a, 32'h00000013);
        chk("miss_b0", inst_b, 32'h0BADF00D);
        step("miss_lo");
        pc = 64'd4;
        #1;
        chk("miss_hi_a", inst_a, 32'h00100093);
        chk("miss_b1", inst_b, 32'h0BADF00D);
        step("miss_hi");

        // Stall hold, sources scrambled after the capture edge
        pc = 64'd8; hit_a = 8'h01; hit_b = 4'h1; id_ready = 1'b0;
        sram_a[31:0] = 32'h00500513; sram_b[64 +: 32] = 32'h00500513;
        #1;
        chk("stall0_a", inst_a, 32'h00500513);
        chk("stall0_b", inst_b, 32'h00500513);
        step("stall0");
        for (int c = 1; c < 3; c++) begin
            rand_sources();
            pc = {$urandom, $urandom};
            #1;
            chk("stall_hold_a", inst_a, 32'h00500513);
            chk("stall_hold_b", inst_b, 32'h00500513);
            chk("stall_ready", 32'(ready_a), 32'd0);
            step("stall");
        end
        id_ready = 1'b1;
        step("stall_release");
        rand_sources();
        step("after_release");

        // Flush while holding
        pc = 64'd8; id_ready = 1'b0; hit_a = 8'h02; hit_b = 4'h2;
        sram_a[1*64 +: 32] = 32'h11110001;
        step("flush_cap");
        flush = 1'b1;
        #1;
        chk("flush_valid", 32'(valid_a), 32'd0);
        step("flush");
        flush = 1'b0; id_ready = 1'b1; hit_a = 8'h04;
        sram_a[2*64 +: 32] = 32'h22220002;
        #1;
        chk("flush_live", inst_a, 32'h22220002);
        step("post_flush");

        // Kill in LIVE: no capture
        kill = 1'b1; id_ready = 1'b0;
        #1;
        chk("kill_ready", 32'(ready_a), 32'd1);
        step("kill");
        kill = 1'b0; id_ready = 1'b1; hit_a = 8'h10;
        sram_a[4*64 +: 32] = 32'h44440004;
        #1;
        chk("kill_nocap", inst_a, 32'h44440004);
        step("post_kill");

        // Multi-hit picks lowest way
        hit_a = 8'h24; hit_b = 4'b0110;
        sram_a[5*64 +: 32] = 32'h55550005;
        #1;
        chk("multi_inst", inst_a, 32'h22220002);
        chk("multi_err", 32'(err_a), 32'd1);
        step("multi");

        // Trap: ready forced high
        hit_a = 8'h01; trap = 4'h1; id_ready = 1'b0;
        #1;
        chk("trap_ready", 32'(ready_a), 32'd1);
        chk("trap_pass", 32'(trap_a), 32'h1);
        step("trap");
        trap = 4'h0; id_ready = 1'b1;
        step("trap_release");

        // Reset mid-HOLD
        id_ready = 1'b0; hit_a = 8'h01;
        step("rh_cap");
        rand_sources();
        step("rh_hold");
        rst = 1'b1;
        step("rh_rst");
        rst = 1'b0;
        #1;
        chk("rh_hold_a", dut_a.hold_q, 32'd0);
        chk("rh_hold_b", dut_b.hold_q, 32'd0);
        rand_sources();
        step("rh_live");
        id_ready = 1'b1;
        step("rh_go");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int m = int'($urandom_range(0, 3));
            rand_sources();
            if (m == 0) begin
                hit_a = '0; hit_b = '0;
            end else if (m == 1) begin
                hit_a = 8'h01 << $urandom_range(0, 7);
                hit_b = 4'h1 << $urandom_range(0, 3);
            end
            pc       = {$urandom, $urandom};
            valid    = ($urandom_range(0, 7) != 0);
            kill     = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            id_ready = ($urandom_range(0, 1) == 0);
            trap     = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0;
            rst      = ($urandom_range(0, 49) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
